// File: rtl/iob_native2axi.sv
// Native-bus slave to AXI4 master bridge: one single-beat INCR transaction at a time.
// The 32-bit native word is placed on the wide AXI bus by a lane taken from the low address bits.
module iob_native2axi #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned AXI_ADDR_W = 30,
  parameter int unsigned AXI_DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid,
  input  logic [ADDR_W-1:0]         address,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [DATA_W/8-1:0]       wstrb,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ready,
  output logic                      axi_err,
  output logic                      m_axi_awid,
  output logic [AXI_ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]                m_axi_awlen,
  output logic [2:0]                m_axi_awsize,
  output logic [1:0]                m_axi_awburst,
  output logic                      m_axi_awlock,
  output logic [3:0]                m_axi_awcache,
  output logic [2:0]                m_axi_awprot,
  output logic [3:0]                m_axi_awqos,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [AXI_DATA_W-1:0]     m_axi_wdata,
  output logic [AXI_DATA_W/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wlast,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic                      m_axi_bid,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic                      m_axi_arid,
  output logic [AXI_ADDR_W-1:0]     m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arlock,
  output logic [3:0]                m_axi_arcache,
  output logic [2:0]                m_axi_arprot,
  output logic [3:0]                m_axi_arqos,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic                      m_axi_rid,
  input  logic [AXI_DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready
);

  localparam int unsigned STRB_W = AXI_DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned LANE_W = (OFF_W > 2) ? OFF_W - 2 : 1;
  localparam int unsigned NLANES = AXI_DATA_W / 32;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_DATA, S_DONE
  } state_t;

  state_t                  r_state;
  logic [AXI_ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]       r_wdata;
  logic [3:0]              r_wstrb;
  logic [LANE_W-1:0]       r_lane;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_arvalid;
  logic                    r_bready;
  logic                    r_rready;
  logic                    r_ready;
  logic                    r_err;
  logic [DATA_W-1:0]       r_rdata;

  logic [LANE_W-1:0]       w_lane;
  logic [AXI_ADDR_W-1:0]   w_axi_addr;
  logic [AXI_DATA_W-1:0]   w_rshift;
  logic                    w_aw_done;
  logic                    w_w_done;
  logic                    w_unused;

  // Lane index exists only when the AXI bus is wider than one native word
  if (OFF_W > 2) begin : g_lane
    assign w_lane = address[OFF_W-1:2];
  end else begin : g_nolane
    assign w_lane = '0;
  end

  assign w_axi_addr = address[AXI_ADDR_W-1:0] & ~AXI_ADDR_W'(STRB_W - 1);
  assign w_rshift   = m_axi_rdata >> {r_lane, 5'b00000};
  assign w_aw_done  = ~r_awvalid | m_axi_awready;
  assign w_w_done   = ~r_wvalid  | m_axi_wready;
  assign w_unused   = &{1'b0, m_axi_bid, m_axi_rid, m_axi_rlast, address, w_rshift};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_lane    <= '0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_arvalid <= 1'b0;
      r_bready  <= 1'b0;
      r_rready  <= 1'b0;
      r_ready   <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid) begin
            r_addr    <= w_axi_addr;
            r_wdata   <= wdata;
            r_wstrb   <= wstrb;
            r_lane    <= w_lane;
            r_awvalid <= |wstrb;
            r_wvalid  <= |wstrb;
            r_arvalid <= ~|wstrb;
            r_state   <= (|wstrb) ? S_WR_REQ : S_RD_REQ;
          end
        end
        // AW and W complete independently, in either order
        S_WR_REQ: begin
          if (r_awvalid && m_axi_awready) r_awvalid <= 1'b0;
          if (r_wvalid && m_axi_wready)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (m_axi_bvalid) begin
            r_bready <= 1'b0;
            r_err    <= |m_axi_bresp;
            r_ready  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_RD_REQ: begin
          if (m_axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (m_axi_rvalid) begin
            r_rready <= 1'b0;
            r_rdata  <= w_rshift[DATA_W-1:0];
            r_err    <= |m_axi_rresp;
            r_ready  <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        // Held valid is not sampled here, so it cannot retrigger
        S_DONE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rdata   = r_rdata;
  assign ready   = r_ready;
  assign axi_err = r_err;

  assign m_axi_awid    = 1'b0;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'(OFF_W);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;
  assign m_axi_awvalid = r_awvalid;

  assign m_axi_wdata   = {NLANES{r_wdata}};
  assign m_axi_wstrb   = STRB_W'(r_wstrb) << {r_lane, 2'b00};
  assign m_axi_wlast   = 1'b1;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;

  assign m_axi_arid    = 1'b0;
  assign m_axi_araddr  = r_addr;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'(OFF_W);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'd0;
  assign m_axi_arqos   = 4'd0;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;

endmodule

// File: tb/tb_iob_native2axi.sv
// Directed bench for iob_native2axi: a 32-bit and a 256-bit AXI instance share one slave model.
module tb_iob_native2axi;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared native request fields; each instance has its own valid
  logic        va, vb;
  logic [31:0] address, wdata;
  logic [3:0]  wstrb;

  // Shared slave-side drive; the idle instance ignores it
  logic         s_awready, s_wready, s_bvalid, s_arready, s_rvalid, s_rlast;
  logic [1:0]   s_bresp, s_rresp;
  logic [255:0] s_rdata;

  // 32-bit instance outputs
  logic [31:0] a_rdata;  logic a_ready, a_err;
  logic a_awid, a_awlock, a_awvalid, a_wlast, a_wvalid, a_bready;
  logic [29:0] a_awaddr, a_araddr;
  logic [7:0] a_awlen, a_arlen; logic [2:0] a_awsize, a_awprot, a_arsize, a_arprot;
  logic [1:0] a_awburst, a_arburst; logic [3:0] a_awcache, a_awqos, a_arcache, a_arqos;
  logic [31:0] a_wdata; logic [3:0] a_wstrb;
  logic a_arid, a_arlock, a_arvalid, a_rready;

  // 256-bit instance outputs
  logic [31:0] b_rdata;  logic b_ready, b_err;
  logic b_awid, b_awlock, b_awvalid, b_wlast, b_wvalid, b_bready;
  logic [29:0] b_awaddr, b_araddr;
  logic [7:0] b_awlen, b_arlen; logic [2:0] b_awsize, b_awprot, b_arsize, b_arprot;
  logic [1:0] b_awburst, b_arburst; logic [3:0] b_awcache, b_awqos, b_arcache, b_arqos;
  logic [255:0] b_wdata; logic [31:0] b_wstrb;
  logic b_arid, b_arlock, b_arvalid, b_rready;

  iob_native2axi #(.AXI_DATA_W(32)) u_a (
    .clk(clk), .rst(rst), .valid(va), .address(address), .wdata(wdata), .wstrb(wstrb),
    .rdata(a_rdata), .ready(a_ready), .axi_err(a_err),
    .m_axi_awid(a_awid), .m_axi_awaddr(a_awaddr), .m_axi_awlen(a_awlen), .m_axi_awsize(a_awsize),
    .m_axi_awburst(a_awburst), .m_axi_awlock(a_awlock), .m_axi_awcache(a_awcache),
    .m_axi_awprot(a_awprot), .m_axi_awqos(a_awqos), .m_axi_awvalid(a_awvalid),
    .m_axi_awready(s_awready),
    .m_axi_wdata(a_wdata), .m_axi_wstrb(a_wstrb), .m_axi_wlast(a_wlast), .m_axi_wvalid(a_wvalid),
    .m_axi_wready(s_wready),
    .m_axi_bid(1'b0), .m_axi_bresp(s_bresp), .m_axi_bvalid(s_bvalid), .m_axi_bready(a_bready),
    .m_axi_arid(a_arid), .m_axi_araddr(a_araddr), .m_axi_arlen(a_arlen), .m_axi_arsize(a_arsize),
    .m_axi_arburst(a_arburst), .m_axi_arlock(a_arlock), .m_axi_arcache(a_arcache),
    .m_axi_arprot(a_arprot), .m_axi_arqos(a_arqos), .m_axi_arvalid(a_arvalid),
    .m_axi_arready(s_arready),
    .m_axi_rid(1'b0), .m_axi_rdata(s_rdata[31:0]), .m_axi_rresp(s_rresp), .m_axi_rlast(s_rlast),
    .m_axi_rvalid(s_rvalid), .m_axi_rready(a_rready)
  );

  iob_native2axi #(.AXI_DATA_W(256)) u_b (
    .clk(clk), .rst(rst), .valid(vb), .address(address), .wdata(wdata), .wstrb(wstrb),
    .rdata(b_rdata), .ready(b_ready), .axi_err(b_err),
    .m_axi_awid(b_awid), .m_axi_awaddr(b_awaddr), .m_axi_awlen(b_awlen), .m_axi_awsize(b_awsize),
    .m_axi_awburst(b_awburst), .m_axi_awlock(b_awlock), .m_axi_awcache(b_awcache),
    .m_axi_awprot(b_awprot), .m_axi_awqos(b_awqos), .m_axi_awvalid(b_awvalid),
    .m_axi_awready(s_awready),
    .m_axi_wdata(b_wdata), .m_axi_wstrb(b_wstrb), .m_axi_wlast(b_wlast), .m_axi_wvalid(b_wvalid),
    .m_axi_wready(s_wready),
    .m_axi_bid(1'b0), .m_axi_bresp(s_bresp), .m_axi_bvalid(s_bvalid), .m_axi_bready(b_bready),
    .m_axi_arid(b_arid), .m_axi_araddr(b_araddr), .m_axi_arlen(b_arlen), .m_axi_arsize(b_arsize),
    .m_axi_arburst(b_arburst), .m_axi_arlock(b_arlock), .m_axi_arcache(b_arcache),
    .m_axi_arprot(b_arprot), .m_axi_arqos(b_arqos), .m_axi_arvalid(b_arvalid),
    .m_axi_arready(s_arready),
    .m_axi_rid(1'b0), .m_axi_rdata(s_rdata), .m_axi_rresp(s_rresp), .m_axi_rlast(s_rlast),
    .m_axi_rvalid(s_rvalid), .m_axi_rready(b_rready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic slave_idle();
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
    s_arready = 0; s_rvalid = 0; s_rresp = 0; s_rlast = 0; s_rdata = '0;
  endtask

  initial begin
    logic [255:0] rd_pattern;
    rst = 1; va = 0; vb = 0; address = 0; wdata = 0; wstrb = 0;
    slave_idle();
    tick(); tick();
    chk("rst_ready", a_ready, 0);
    chk("rst_err", a_err, 0);
    chk("rst_rdata", a_rdata, 0);
    chk("rst_valids", {a_awvalid, a_wvalid, a_arvalid, a_bready, a_rready}, 0);
    chk("rst_b_valids", {b_awvalid, b_wvalid, b_arvalid, b_bready, b_rready, b_ready}, 0);
    rst = 0;
    tick();

    // Write, 32-bit bus, all slave responses immediate
    va = 1; address = 32'h100; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    s_awready = 1; s_wready = 1; s_bvalid = 1; s_bresp = 0;
    tick();                                                   // cycle 1
    chk("w1_awvalid", {a_awvalid, a_wvalid}, 2'b11);
    chk("w1_awaddr", a_awaddr, 30'h100);
    chk("w1_wdata", a_wdata, 32'hDEADBEEF);
    chk("w1_wstrb", a_wstrb, 4'hF);
    chk("w1_len_last", {a_awlen, a_wlast}, {8'd0, 1'b1});
    chk("w1_consts", {a_awid, a_awsize, a_awburst, a_awlock, a_awcache, a_awprot, a_awqos},
        {1'b0, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0});
    chk("w1_ready_c1", a_ready, 0);
    tick();                                                   // cycle 2
    chk("w1_c2", {a_awvalid, a_wvalid, a_bready, a_ready}, 4'b0010);
    tick();                                                   // cycle 3
    chk("w1_ready_c3", {a_ready, a_err, a_bready}, 3'b100);
    va = 0; slave_idle();
    tick();                                                   // cycle 4
    chk("w1_ready_c4", a_ready, 0);

    // Write with W delayed until cycle 4
    va = 1; address = 32'h104; wdata = 32'h01020304; wstrb = 4'h1;
    s_awready = 1;
    tick();                                                   // cycle 1
    chk("w2_c1", {a_awvalid, a_wvalid}, 2'b11);
    tick(); s_awready = 0;                                    // cycle 2
    chk("w2_c2", {a_awvalid, a_wvalid, a_bready}, 3'b010);
    tick();                                                   // cycle 3
    chk("w2_c3", {a_awvalid, a_wvalid, a_bready}, 3'b010);
    tick(); s_wready = 1;                                     // cycle 4
    chk("w2_c4", {a_awvalid, a_wvalid, a_bready}, 3'b010);
    tick(); s_wready = 0;                                     // cycle 5
    chk("w2_c5", {a_awvalid, a_wvalid, a_bready, a_ready}, 4'b0010);
    tick();                                                   // cycle 6: bvalid now
    chk("w2_c6_wait", {a_bready, a_ready}, 2'b10);
    s_bvalid = 1;
    tick();                                                   // cycle 7
    chk("w2_ready", {a_ready, a_err}, 2'b10);
    va = 0; slave_idle();
    tick();
    chk("w2_after", a_ready, 0);

    // Read, 256-bit bus, lane 7, five stall cycles on R
    vb = 1; address = 32'h1C; wstrb = 0; s_arready = 1;
    tick();                                                   // cycle 1
    chk("r3_arvalid", b_arvalid, 1);
    chk("r3_araddr", b_araddr, 30'h0);
    chk("r3_consts", {b_arlen, b_arsize, b_arburst, b_arcache}, {8'd0, 3'd5, 2'b01, 4'b0011});
    tick(); s_arready = 0;                                    // cycle 2
    chk("r3_c2", {b_arvalid, b_rready, b_ready}, 3'b010);
    for (int i = 0; i < 4; i++) begin
      tick();                                                 // cycles 3..6
      chk("r3_stall", {b_rready, b_ready}, 2'b10);
    end
    tick();                                                   // cycle 7: rvalid
    rd_pattern = {8{32'hA5A5A5A5}};
    rd_pattern[255:224] = 32'h12345678;
    s_rdata = rd_pattern; s_rvalid = 1; s_rlast = 1;
    tick();                                                   // cycle 8
    chk("r3_ready", {b_ready, b_err, b_rready}, 3'b100);
    chk("r3_rdata", b_rdata, 32'h12345678);
    vb = 0; slave_idle();
    tick();
    chk("r3_single", b_ready, 0);

    // Write, 256-bit bus, lane 7, two byte enables
    vb = 1; address = 32'h1C; wdata = 32'hCAFEF00D; wstrb = 4'h3;
    s_awready = 1; s_wready = 1; s_bvalid = 1;
    tick();
    chk("w4_awaddr", b_awaddr, 30'h0);
    chk("w4_wstrb", b_wstrb, 32'h3000_0000);
    chk("w4_wdata", b_wdata, {8{32'hCAFEF00D}});
    chk("w4_size", b_awsize, 3'd5);
    tick(); tick();
    chk("w4_ready", {b_ready, b_err}, 2'b10);
    vb = 0; slave_idle();
    tick();

    // Error responses: bresp=SLVERR then rresp=DECERR
    va = 1; address = 32'h20; wdata = 32'h11111111; wstrb = 4'hF;
    s_awready = 1; s_wready = 1; s_bvalid = 1; s_bresp = 2'b10;
    tick(); tick();
    chk("e5_w_c2", {a_ready, a_err}, 2'b00);
    tick();
    chk("e5_w_c3", {a_ready, a_err}, 2'b11);
    va = 0; slave_idle();
    tick();
    chk("e5_w_c4", {a_ready, a_err}, 2'b00);
    va = 1; address = 32'h40; wstrb = 0;
    s_arready = 1; s_rvalid = 1; s_rresp = 2'b11; s_rdata = {224'd0, 32'h55AA33CC};
    tick();
    chk("e5_araddr", {a_arvalid, a_araddr}, {1'b1, 30'h40});
    tick();
    chk("e5_r_c2", {a_rready, a_ready, a_err}, 3'b100);
    tick();
    chk("e5_r_c3", {a_ready, a_err}, 2'b11);
    chk("e5_rdata", a_rdata, 32'h55AA33CC);
    va = 0; slave_idle();
    tick();
    chk("e5_r_c4", {a_ready, a_err}, 2'b00);

    // Reset while waiting in RD_DATA with valid still held
    va = 1; address = 32'h80; wstrb = 0; s_arready = 1;
    tick(); tick(); s_arready = 0;                            // cycle 2: RD_DATA
    chk("x6_in_rdata", a_rready, 1);
    rst = 1;
    tick();
    chk("x6_rst_out", {a_ready, a_err, a_awvalid, a_wvalid, a_arvalid, a_bready, a_rready}, 0);
    chk("x6_rst_rdata", a_rdata, 0);
    va = 0; s_rvalid = 1; s_rdata = {224'd0, 32'hFFFF0000};
    tick();
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("x6_no_ready", {a_ready, a_rready, a_arvalid}, 0);
    end
    slave_idle();
    tick();

    // A normal write completes after the abandoned read
    va = 1; address = 32'h200; wdata = 32'h0BADF00D; wstrb = 4'b0110;
    s_awready = 1; s_wready = 1; s_bvalid = 1;
    tick();
    chk("x6_w_awaddr", a_awaddr, 30'h200);
    chk("x6_w_wstrb", {a_wdata, a_wstrb}, {32'h0BADF00D, 4'b0110});
    tick(); tick();
    chk("x6_w_ready", {a_ready, a_err}, 2'b10);
    va = 0; slave_idle();
    tick();
    chk("x6_w_end", a_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
